// File: rtl/prco_uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, CLKS_PER_BIT clocks per bit.
// Define PRCO_UART_RX_PARITY_EN to add an even-parity bit between D7 and STOP.
module prco_uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx,
    output logic [7:0] q_8bit_data,
    output logic       q_new_data,
    output logic       q_busy,
    output logic       q_frame_err,
    output logic       q_parity_err
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic             rx_s1;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       shreg;
    logic [2:0]       bit_idx;
    logic             brk;
    logic             tick_full;
`ifdef PRCO_UART_RX_PARITY_EN
    logic             par_bit;
`endif

    assign tick_full = (cnt == CNT_FULL);
    assign q_busy    = (state != IDLE);

    // Flops preset to 1 so reset never fabricates a falling edge on the line.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_s1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_s1 <= i_rx;
            rx_s  <= rx_s1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            brk         <= 1'b0;
            q_8bit_data <= '0;
            q_new_data  <= 1'b0;
            q_frame_err <= 1'b0;
`ifdef PRCO_UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            q_parity_err <= 1'b0;
`endif
        end else begin
            q_new_data  <= 1'b0;
            q_frame_err <= 1'b0;
`ifdef PRCO_UART_RX_PARITY_EN
            q_parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tick_full) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef PRCO_UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef PRCO_UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_full) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    // brk holds the FSM busy after a framing error until the line is seen idle.
                    if (brk) begin
                        if (rx_s) begin
                            brk   <= 1'b0;
                            state <= IDLE;
                        end
                    end else if (tick_full) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
`ifdef PRCO_UART_RX_PARITY_EN
                            if (par_bit != ^shreg) begin
                                q_parity_err <= 1'b1;
                            end else begin
                                q_8bit_data <= shreg;
                                q_new_data  <= 1'b1;
                            end
`else
                            q_8bit_data <= shreg;
                            q_new_data  <= 1'b1;
`endif
                        end else begin
                            q_frame_err <= 1'b1;
                            brk         <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef PRCO_UART_RX_PARITY_EN
    assign q_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_prco_uart_rx.sv
// Directed bench for prco_uart_rx at CLKS_PER_BIT=8; covers the parity build when
// PRCO_UART_RX_PARITY_EN is defined.
module tb_prco_uart_rx;

    localparam int unsigned CPB = 8;
`ifdef PRCO_UART_RX_PARITY_EN
    localparam int LAT   = 87;
    localparam int FRAME = 88;
`else
    localparam int LAT   = 79;
    localparam int FRAME = 80;
`endif

    logic       i_clk;
    logic       i_rst;
    logic       i_rx;
    logic [7:0] q_8bit_data;
    logic       q_new_data;
    logic       q_busy;
    logic       q_frame_err;
    logic       q_parity_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int fe_cnt = 0;
    int pe_cnt = 0;
    int excl   = 0;
    int nd_cyc[$];
    logic [7:0] nd_dat[$];
    int start;

    prco_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_rx         (i_rx),
        .q_8bit_data  (q_8bit_data),
        .q_new_data   (q_new_data),
        .q_busy       (q_busy),
        .q_frame_err  (q_frame_err),
        .q_parity_err (q_parity_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Output monitor: samples 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (q_new_data === 1'b1) begin
                nd_cyc.push_back(cyc);
                nd_dat.push_back(q_8bit_data);
            end
            if (q_frame_err === 1'b1) fe_cnt++;
            if (q_parity_err === 1'b1) pe_cnt++;
            if (int'(q_new_data) + int'(q_frame_err) + int'(q_parity_err) > 1) excl++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    task automatic clear_mon();
        nd_cyc.delete();
        nd_dat.delete();
        fe_cnt = 0;
        pe_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input logic par_flip);
        logic [10:0] f;
        int n;
`ifdef PRCO_UART_RX_PARITY_EN
        f = {stop, (^d) ^ par_flip, d, 1'b0};
        n = 11;
`else
        f = {1'b0, stop, d, 1'b0};
        n = 10;
        if (par_flip) f = {1'b0, stop, d, 1'b0};
`endif
        for (int i = 0; i < n; i++) begin
            i_rx = f[i];
            tick(CPB);
        end
        i_rx = 1'b1;
    endtask

    initial begin
        i_rx  = 1'b1;
        i_rst = 1'b1;
        tick(3);
        check("rst_data", 32'(q_8bit_data), 32'h00);
        check("rst_new", 32'(q_new_data), 32'd0);
        check("rst_busy", 32'(q_busy), 32'd0);
        check("rst_ferr", 32'(q_frame_err), 32'd0);
        check("rst_perr", 32'(q_parity_err), 32'd0);
        i_rst = 1'b0;
        tick(5);

        // Single good frame, exact pulse timing
        clear_mon();
        start = cyc;
        send_byte(8'hA5, 1'b1, 1'b0);
        tick(4);
        check("a5_count", 32'(nd_cyc.size()), 32'd1);
        check("a5_lat", 32'(nd_cyc[0] - start), 32'(LAT));
        check("a5_pdata", 32'(nd_dat[0]), 32'hA5);
        check("a5_hold", 32'(q_8bit_data), 32'hA5);
        check("a5_ferr", 32'(fe_cnt), 32'd0);
        check("a5_perr", 32'(pe_cnt), 32'd0);
        check("a5_idle", 32'(q_busy), 32'd0);

        // Back-to-back frames
        clear_mon();
        start = cyc;
        send_byte(8'h3C, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        tick(4);
        check("b2b_count", 32'(nd_cyc.size()), 32'd2);
        check("b2b_d0", 32'(nd_dat[0]), 32'h3C);
        check("b2b_d1", 32'(nd_dat[1]), 32'hFF);
        check("b2b_lat", 32'(nd_cyc[0] - start), 32'(LAT));
        check("b2b_gap", 32'(nd_cyc[1] - nd_cyc[0]), 32'(FRAME));

        // 3-cycle glitch is rejected at the mid-start sample
        clear_mon();
        i_rx = 1'b0;
        tick(3);
        i_rx = 1'b1;
        check("gl_busy", 32'(q_busy), 32'd1);
        tick(5);
        check("gl_drop", 32'(q_busy), 32'd0);
        check("gl_none", 32'(nd_cyc.size() + fe_cnt + pe_cnt), 32'd0);
        tick(4);
        send_byte(8'h55, 1'b1, 1'b0);
        tick(4);
        check("gl_55cnt", 32'(nd_cyc.size()), 32'd1);
        check("gl_55", 32'(q_8bit_data), 32'h55);

        // Framing error followed by a long break
        clear_mon();
        send_byte(8'h81, 1'b0, 1'b0);
        i_rx = 1'b0;
        tick(20 * CPB);
        check("fe_count", 32'(fe_cnt), 32'd1);
        check("fe_nonew", 32'(nd_cyc.size()), 32'd0);
        check("fe_hold", 32'(q_8bit_data), 32'h55);
        check("fe_busy", 32'(q_busy), 32'd1);
        i_rx = 1'b1;
        tick(5);
        check("fe_rearm", 32'(q_busy), 32'd0);
        check("fe_still1", 32'(fe_cnt), 32'd1);
        send_byte(8'h96, 1'b1, 1'b0);
        tick(4);
        check("fe_next", 32'(q_8bit_data), 32'h96);
        check("fe_nextcnt", 32'(nd_cyc.size()), 32'd1);

        // Reset during D4 discards the partial byte
        clear_mon();
        begin
            logic [7:0] d12;
            d12 = 8'h12;
            i_rx = 1'b0;
            tick(CPB);
            for (int i = 0; i < 4; i++) begin
                i_rx = d12[i];
                tick(CPB);
            end
            i_rx = d12[4];
            tick(3);
        end
        check("mr_busy", 32'(q_busy), 32'd1);
        i_rst = 1'b1;
        #1;
        check("mr_data", 32'(q_8bit_data), 32'h00);
        check("mr_busy0", 32'(q_busy), 32'd0);
        check("mr_new", 32'(q_new_data), 32'd0);
        i_rx = 1'b1;
        tick(2);
        i_rst = 1'b0;
        tick(CPB * 12);
        check("mr_nopulse", 32'(nd_cyc.size() + fe_cnt + pe_cnt), 32'd0);
        send_byte(8'h34, 1'b1, 1'b0);
        tick(4);
        check("mr_34cnt", 32'(nd_cyc.size()), 32'd1);
        check("mr_34", 32'(q_8bit_data), 32'h34);

`ifdef PRCO_UART_RX_PARITY_EN
        clear_mon();
        start = cyc;
        send_byte(8'h07, 1'b1, 1'b0);
        tick(4);
        check("par_cnt", 32'(nd_cyc.size()), 32'd1);
        check("par_lat", 32'(nd_cyc[0] - start), 32'd87);
        check("par_data", 32'(q_8bit_data), 32'h07);
        clear_mon();
        send_byte(8'h07, 1'b1, 1'b1);
        tick(4);
        check("perr_cnt", 32'(pe_cnt), 32'd1);
        check("perr_nonew", 32'(nd_cyc.size()), 32'd0);
        check("perr_ferr", 32'(fe_cnt), 32'd0);
        check("perr_hold", 32'(q_8bit_data), 32'h07);
`else
        check("noparity_tie", 32'(pe_cnt), 32'd0);
`endif

        check("exclusive", 32'(excl), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prco_uart_rx.md
PRCO_UART_RX -- requirements
Module: prco_uart_rx

Interface
REQ-001 The module SHALL have parameter CLKS_PER_BIT, default 868, giving i_clk cycles per UART bit; legal range 4..65535.
REQ-002 The module SHALL have port i_clk, input, 1 bit, the single clock; all state SHALL be clocked on its rising edge.
REQ-003 The module SHALL have port i_rst, input, 1 bit, reset; it SHALL be asynchronous and active-high.
REQ-004 The module SHALL have port i_rx, input, 1 bit, asynchronous serial line; it idles high.
REQ-005 The module SHALL have port q_8bit_data, output reg, 8 bits, last correctly received byte, suitable for the prco_io i_8bit_data input.
REQ-006 The module SHALL have port q_new_data, output reg, 1 bit, one-cycle pulse marking a new valid q_8bit_data.
REQ-007 The module SHALL have port q_busy, output reg, 1 bit, high whenever state is not IDLE.
REQ-008 The module SHALL have port q_frame_err, output reg, 1 bit, one-cycle pulse on stop-bit error.
REQ-009 The module SHALL have port q_parity_err, output reg, 1 bit, one-cycle pulse on parity mismatch.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rx_s.
REQ-011 The frame format SHALL be 1 start bit (low), 8 data bits LSB first, optional parity bit (REQ-030), and 1 stop bit (high).
REQ-012 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE, rx_s==0 at cycle T0 SHALL move to START and clear the bit-timing counter.
REQ-014 START SHALL sample rx_s at T0+CLKS_PER_BIT/2 (integer division); if the sample is 1 (false start), it SHALL return to IDLE with no pulse; if 0, it SHALL go to DATA.
REQ-015 Each later bit SHALL be sampled exactly CLKS_PER_BIT cycles after the previous sample.
REQ-016 Data bit n SHALL be shifted into bit n of the shift register; DATA SHALL exit after the 8th sample.
REQ-017 If the STOP sample is 1 and there is no parity error, then on the next cycle q_8bit_data SHALL equal the shift register and q_new_data SHALL be 1 for exactly one cycle.
REQ-018 If the STOP sample is 0, then on the next cycle q_frame_err SHALL pulse for one cycle; q_new_data SHALL stay 0 and q_8bit_data SHALL be unchanged.
REQ-019 The FSM SHALL return to IDLE on the cycle after the STOP sample, without waiting for the end of the stop bit, so that back-to-back frames are received.
REQ-020 After a framing error, the FSM SHALL NOT re-arm until rx_s has been observed high (break handling); q_busy SHALL stay high until then.
REQ-021 q_8bit_data SHALL hold its value between valid frames.
REQ-022 q_new_data, q_frame_err and q_parity_err SHALL be mutually exclusive in any cycle.
REQ-023 The bit-timing counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL NOT wrap within a bit.

Reset
REQ-024 Asserting i_rst SHALL immediately force the state to IDLE, clear the counter, shift register and bit index, set both synchronizer flops to 1, and set q_8bit_data=8'h00, q_new_data=0, q_busy=0, q_frame_err=0, q_parity_err=0.
REQ-025 If reset is asserted mid-frame, the partial byte SHALL be discarded with no pulse; after release, reception SHALL resume only on a fresh falling edge.
REQ-026 Release of reset while i_rx is low SHALL be treated as a start condition only after the synchronizer has propagated the low level (2 cycles).

Configuration
REQ-030 Macro PRCO_UART_RX_PARITY_EN, when defined, SHALL enable the PARITY state: one even-parity bit is sampled after D7 and before STOP.
REQ-031 On a parity mismatch with a good stop bit, q_parity_err SHALL pulse for one cycle on the q_new_data slot, and the byte SHALL be discarded; a bad stop bit SHALL report q_frame_err only.
REQ-032 Without PRCO_UART_RX_PARITY_EN, the PARITY state SHALL be unreachable, the frame SHALL be 10 bits, and q_parity_err SHALL be tied to 0.

Verification (CLKS_PER_BIT=8)
REQ-040 Send 0xA5 with a valid stop bit -> q_new_data is high for 1 cycle at T0+77, q_8bit_data=8'hA5, and no error pulses.
REQ-041 Send 0x3C then 0xFF back-to-back with no idle gap -> two q_new_data pulses 80 cycles apart with data 3C then FF.
REQ-042 Drive a 3-cycle low glitch on i_rx -> no pulses, q_busy drops after the mid-start sample, and the next 0x55 frame is received correctly.
REQ-043 Send 0x81 with the stop bit low, then hold the line low for 20 bit times -> one q_frame_err pulse, q_8bit_data unchanged, and no new frame until the line goes high.
REQ-044 Assert i_rst during D4 of a 0x12 frame -> all outputs go to 0 immediately, no pulse occurs, and a following 0x34 frame is received correctly.
REQ-045 With PRCO_UART_RX_PARITY_EN defined, send 0x07 with parity 1 -> q_new_data with 8'h07 at T0+85; send 0x07 with parity 0 -> q_parity_err pulse and q_8bit_data unchanged.
